risc_fetch_stage: RTL and testbench

//  RiSC-16 instruction fetch stage. Holds the PC, issues instruction-memory reads (one outstanding),

---
 rtl/risc_pkg.sv | 38 +++
 rtl/fetch_buf.sv | 67 ++++++
 rtl/risc_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_risc_fetch_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg -- shared RiSC-16 definitions for the fetch stage.
//   * opcode constants ADD_OP..JALR_OP (instr[15:13])
//   * instruction field bit positions
//   * fetch FSM state enum {FETCH, WAIT, DISCARD}
//   * sext7: sign-extends the 7-bit immediate to 16 bits
package risc_pkg;

    localparam logic [2:0] ADD_OP  = 3'b000;
    localparam logic [2:0] ADDI_OP = 3'b001;
    localparam logic [2:0] NAND_OP = 3'b010;
    localparam logic [2:0] LUI_OP  = 3'b011;
    localparam logic [2:0] SW_OP   = 3'b100;
    localparam logic [2:0] LW_OP   = 3'b101;
    localparam logic [2:0] BEQ_OP  = 3'b110;
    localparam logic [2:0] JALR_OP = 3'b111;

    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 13;
    localparam int RA_HI    = 12;
    localparam int RA_LO    = 10;
    localparam int RB_HI    = 9;
    localparam int RB_LO    = 7;
    localparam int RC_HI    = 2;
    localparam int RC_LO    = 0;
    localparam int SIMM_HI  = 6;
    localparam int IMM10_HI = 9;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,   // no request outstanding
        WAIT    = 2'd1,   // request accepted, waiting for its word
        DISCARD = 2'd2    // request outstanding but its word is stale
    } fetch_state_e;

    function automatic logic [15:0] sext7(input logic [6:0] v);
        return {{9{v[6]}}, v};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf -- small synchronous FIFO of {pc, instr} pairs.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush_i              empties the FIFO (wins over push/pop)
//   push_i, push_pc_i,
//   push_instr_i         write one entry at the tail
//   pop_i                drop the head entry (caller guarantees non-empty)
//   head_pc_o,
//   head_instr_o         current head entry (combinational from storage)
//   count_o              number of valid entries
// The caller guarantees no push when full (space is reserved at request time).
module fetch_buf #(
    parameter int PC_W  = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [PC_W-1:0]          push_pc_i,
    input  logic [15:0]              push_instr_i,
    input  logic                     pop_i,
    output logic [PC_W-1:0]          head_pc_o,
    output logic [15:0]              head_instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = PC_W + 16;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    // Entry storage carries no reset; validity is tracked by count_q alone.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_i && !flush_i && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= {push_pc_i, push_instr_i};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign {head_pc_o, head_instr_o} = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/risc_fetch_stage.sv
// risc_fetch_stage -- RiSC-16 instruction fetch stage.
// Holds the PC, issues one outstanding instruction-memory read at a time,
// buffers returned words in fetch_buf and presents decoded fields of the
// buffer head to decode over valid/ready. Execute redirects flush the stage.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         read request (addr = word address)
//   imem_rsp_valid/data               returned instruction word
//   id_valid/ready                    head-of-buffer handshake to decode
//   id_pc, id_opcode, id_ra, id_rb,
//   id_rc, id_simm, id_imm10          decoded fields of the head word
//   redirect_valid/pc                 taken branch / JALR target from execute
//   halted                            fetch stopped on HALT
// Optional feature: define RISC_FETCH_HALT_EN to stop fetching after a HALT
// word (JALR opcode with non-zero instr[6:0]); otherwise halted is tied 0.
module risc_fetch_stage
    import risc_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [15:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [PC_W-1:0] id_pc,
    output logic [2:0]      id_opcode,
    output logic [2:0]      id_ra,
    output logic [2:0]      id_rb,
    output logic [2:0]      id_rc,
    output logic [15:0]     id_simm,
    output logic [9:0]      id_imm10,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted
);
    localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic             req_valid_q, req_valid_d;
    logic             req_fire, push, pop, halt_block;
    logic [CNT_W-1:0] count, cnt_d;
    logic [PC_W-1:0]  head_pc;
    logic [15:0]      head_instr;

    always_comb begin
        req_fire = req_valid_q && imem_req_ready;
        // A redirect makes the same-cycle response and pop meaningless.
        push     = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
        pop      = id_valid && id_ready && !redirect_valid;

        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        case (state_q)
            FETCH: begin
                if (req_fire) begin
                    // An accepted request's word is stale if a redirect lands
                    // in the same cycle, so it must be absorbed in DISCARD.
                    state_d  = redirect_valid ? DISCARD : WAIT;
                    pc_d     = pc_q + PC_W'(1);
                    req_pc_d = pc_q;
                end
            end
            WAIT: begin
                // A response arriving with the redirect closes the
                // transaction; only a still-missing one needs DISCARD.
                if (imem_rsp_valid)      state_d = FETCH;
                else if (redirect_valid) state_d = DISCARD;
            end
            DISCARD: begin
                if (imem_rsp_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (redirect_valid) pc_d = redirect_pc;

        cnt_d = count;
        if (redirect_valid) begin
            cnt_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt_d = count + CNT_W'(1);
                2'b01:   cnt_d = count - CNT_W'(1);
                default: cnt_d = count;
            endcase
        end

        // Request only while a buffer slot is free for the returning word.
        // Computed from next-state values so a request follows a response
        // without a bubble; stays stable while waiting for ready because
        // nothing can be pushed in FETCH.
        req_valid_d = (state_d == FETCH) && (cnt_d < DEPTH_C) && !halt_block;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

`ifdef RISC_FETCH_HALT_EN
    logic halted_q, halted_d, push_is_halt;

    always_comb begin
        push_is_halt = (imem_rsp_data[OPC_HI:OPC_LO] == JALR_OP) &&
                       (imem_rsp_data[SIMM_HI:0] != 7'd0);
        halted_d     = halted_q;
        if (redirect_valid)            halted_d = 1'b0;
        else if (push && push_is_halt) halted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign halt_block = halted_d;
    assign halted     = halted_q;
`else
    assign halt_block = 1'b0;
    assign halted     = 1'b0;
`endif

    fetch_buf #(
        .PC_W  (PC_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (push),
        .push_pc_i    (req_pc_q),
        .push_instr_i (imem_rsp_data),
        .pop_i        (pop),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (count)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;

    assign id_valid  = (count != '0);
    assign id_pc     = head_pc;
    assign id_opcode = head_instr[OPC_HI:OPC_LO];
    assign id_ra     = head_instr[RA_HI:RA_LO];
    assign id_rb     = head_instr[RB_HI:RB_LO];
    assign id_rc     = head_instr[RC_HI:RC_LO];
    assign id_simm   = sext7(head_instr[SIMM_HI:0]);
    assign id_imm10  = head_instr[IMM10_HI:0];

endmodule

// File: tb/tb_risc_fetch_stage.sv
// Directed testbench for risc_fetch_stage. The memory model answers an
// accepted request one cycle later unless the stimulus drives the response
// by hand. Word at address a is {3'b010, a[12:0] ^ 13'h0A3C}, except that
// address 2 returns HALT (16'hE071) during the HALT test.
module tb_risc_fetch_stage;
    localparam int PC_W = 16;

    logic            clk;
    logic            rst_n;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [PC_W-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [15:0]     imem_rsp_data;
    logic            id_valid;
    logic            id_ready;
    logic [PC_W-1:0] id_pc;
    logic [2:0]      id_opcode;
    logic [2:0]      id_ra;
    logic [2:0]      id_rb;
    logic [2:0]      id_rc;
    logic [15:0]     id_simm;
    logic [9:0]      id_imm10;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            halted;

    logic [15:0] id_instr;
    assign id_instr = {id_opcode, id_ra, id_imm10};

    int checks = 0;
    int errors = 0;
    int issued = 0;
    bit mem_auto = 1'b1;
    bit halt_word_en = 1'b0;

    risc_fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_ra          (id_ra),
        .id_rb          (id_rb),
        .id_rc          (id_rc),
        .id_simm        (id_simm),
        .id_imm10       (id_imm10),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_word_en && a == 16'h0002) return 16'hE071;
        return {3'b010, a[12:0] ^ 13'h0A3C};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample the request handshake before the edge, then drive
    // the memory response for the next edge 1 time unit after it.
    task automatic step();
        logic        hs;
        logic [15:0] a;
        hs = imem_req_valid && imem_req_ready && rst_n;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        if (hs) begin
            issued++;
            $display("t=%0t req addr=%h", $time, a);
        end
        if (mem_auto) begin
            imem_rsp_valid = hs;
            imem_rsp_data  = hs ? mem_word(a) : 16'h0000;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        mem_auto       = 1'b1;
        halt_word_en   = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step();
        step();
        rst_n  = 1'b1;
        issued = 0;
    endtask

    initial begin
        // ---- reset values ----
        do_reset();
        rst_n = 1'b0;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_id_valid",  32'(id_valid),       32'd0);
        check("rst_halted",    32'(halted),         32'd0);
        rst_n = 1'b1;

        // ---- streaming, 1-cycle memory, id_ready=1 ----
        do_reset();
        step();
        check("t1_req_valid", 32'(imem_req_valid), 32'd1);
        check("t1_req_addr0", 32'(imem_req_addr),  32'h0000);
        step();
        step();
        check("t1_id_valid0", 32'(id_valid), 32'd1);
        check("t1_id_pc0",    32'(id_pc),    32'h0000);
        check("t1_instr0",    32'(id_instr), 32'h4A3C);
        check("t1_req_addr1", 32'(imem_req_addr), 32'h0001);
        step();
        check("t1_id_empty",  32'(id_valid), 32'd0);
        step();
        check("t1_id_pc1",    32'(id_pc),    32'h0001);
        check("t1_instr1",    32'(id_instr), 32'h4A3D);
        check("t1_simm_pos",  32'(id_simm),  32'h003D);
        step();
        step();
        check("t1_id_pc2",    32'(id_pc),    32'h0002);
        check("t1_instr2",    32'(id_instr), 32'h4A3E);

        // ---- decode stalled for 10 cycles ----
        do_reset();
        id_ready = 1'b0;
        repeat (10) step();
        check("t2_issued",    32'(issued),         32'd2);
        check("t2_req_valid", 32'(imem_req_valid), 32'd0);
        check("t2_id_valid",  32'(id_valid),       32'd1);
        check("t2_id_pc0",    32'(id_pc),          32'h0000);
        check("t2_instr0",    32'(id_instr),       32'h4A3C);
        id_ready = 1'b1;
        step();
        check("t2_id_pc1",    32'(id_pc),    32'h0001);
        check("t2_instr1",    32'(id_instr), 32'h4A3D);
        step();
        step();
        check("t2_id_pc2",    32'(id_pc),    32'h0002);
        check("t2_issued3",   32'(issued),   32'd3);

        // ---- redirect while WAIT, stale response dropped ----
        do_reset();
        id_ready = 1'b0;
        step();
        step();
        step();
        mem_auto = 1'b0;
        step();
        check("t3_buf_valid", 32'(id_valid), 32'd1);
        check("t3_buf_pc",    32'(id_pc),    32'h0000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        step();
        redirect_valid = 1'b0;
        check("t3_flushed",   32'(id_valid),       32'd0);
        check("t3_no_req",    32'(imem_req_valid), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(16'h0001);
        step();
        imem_rsp_valid = 1'b0;
        check("t3_stale_drop", 32'(id_valid),       32'd0);
        check("t3_req_valid",  32'(imem_req_valid), 32'd1);
        check("t3_req_addr",   32'(imem_req_addr),  32'h0040);
        mem_auto = 1'b1;
        id_ready = 1'b1;
        step();
        step();
        check("t3_id_valid", 32'(id_valid), 32'd1);
        check("t3_id_pc",    32'(id_pc),    32'h0040);
        check("t3_opcode",   32'(id_opcode), 32'd2);
        check("t3_ra",       32'(id_ra),     32'd2);
        check("t3_rb",       32'(id_rb),     32'd4);
        check("t3_rc",       32'(id_rc),     32'd4);
        check("t3_simm_neg", 32'(id_simm),   32'hFFFC);
        check("t3_imm10",    32'(id_imm10),  32'h27C);

        // ---- ready low, PC wrap ----
        do_reset();
        imem_req_ready = 1'b0;
        step();
        check("t4_req_addr0", 32'(imem_req_addr), 32'h0000);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_hold_valid", 32'(imem_req_valid), 32'd1);
            check("t4_hold_addr",  32'(imem_req_addr),  32'hFFFF);
        end
        imem_req_ready = 1'b1;
        step();
        check("t4_issued",    32'(issued),         32'd1);
        check("t4_req_drop",  32'(imem_req_valid), 32'd0);
        step();
        check("t4_wrap_valid", 32'(imem_req_valid), 32'd1);
        check("t4_wrap_addr",  32'(imem_req_addr),  32'h0000);
        check("t4_id_pc",      32'(id_pc),          32'hFFFF);
        check("t4_instr",      32'(id_instr),       32'h55C3);

        // ---- reset with a request outstanding ----
        do_reset();
        id_ready = 1'b0;
        step();
        step();
        step();
        mem_auto = 1'b0;
        step();
        check("t5_pre_valid", 32'(id_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_async_id_valid",  32'(id_valid),       32'd0);
        check("t5_async_req_valid", 32'(imem_req_valid), 32'd0);
        check("t5_async_halted",    32'(halted),         32'd0);
        #1;
        rst_n = 1'b1;
        issued = 0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(16'h0001);
        step();
        imem_rsp_valid = 1'b0;
        check("t5_late_ignored", 32'(id_valid),       32'd0);
        check("t5_req_valid",    32'(imem_req_valid), 32'd1);
        check("t5_req_addr",     32'(imem_req_addr),  32'h0000);
        mem_auto = 1'b1;
        id_ready = 1'b1;
        step();
        step();
        check("t5_id_pc",    32'(id_pc),    32'h0000);
        check("t5_instr",    32'(id_instr), 32'h4A3C);

        // ---- HALT word at address 2 ----
        do_reset();
        halt_word_en = 1'b1;
        repeat (7) step();
        check("t6_id_pc_halt", 32'(id_pc),     32'h0002);
        check("t6_opcode",     32'(id_opcode), 32'd7);
`ifdef RISC_FETCH_HALT_EN
        check("t6_halted",     32'(halted),         32'd1);
        check("t6_no_req",     32'(imem_req_valid), 32'd0);
        step();
        check("t6_drained",    32'(id_valid),       32'd0);
        step();
        step();
        check("t6_still_halt", 32'(halted),         32'd1);
        check("t6_still_noreq", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0010;
        step();
        redirect_valid = 1'b0;
        check("t6_unhalt",     32'(halted),         32'd0);
        check("t6_resume",     32'(imem_req_valid), 32'd1);
        check("t6_resume_addr", 32'(imem_req_addr), 32'h0010);
`else
        check("t6_not_halted", 32'(halted),         32'd0);
        check("t6_keeps_req",  32'(imem_req_valid), 32'd1);
        check("t6_next_addr",  32'(imem_req_addr),  32'h0003);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
